// File: rtl/sphere_pkg.sv
// Shared types for the sphere scan scheduler: scene/ray records and FSM state.
package sphere_pkg;

    localparam int COORD_W = 16;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
        logic signed [COORD_W-1:0] r;
    } sphere_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
        logic signed [COORD_W-1:0] dx;
        logic signed [COORD_W-1:0] dy;
        logic signed [COORD_W-1:0] dz;
    } ray_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/sphere_table.sv
// Scene register file: one synchronous write port, one registered read port with load enable.
module sphere_table
    import sphere_pkg::*;
#(
    parameter int MaxSpheres = 16,
    parameter int IdxW       = $clog2(MaxSpheres)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [IdxW-1:0] wr_addr_i,
    input  sphere_t         wr_data_i,
    input  logic            rd_en_i,
    input  logic [IdxW-1:0] rd_addr_i,
    output sphere_t         rd_data_o
);

    sphere_t mem_q [MaxSpheres];
    sphere_t rd_data_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sphere_scan_scheduler.sv
// Issues each scene sphere to the discriminant calculator for one ray and
// reports the nearest forward hit (largest negative B, lowest index on ties).
module sphere_scan_scheduler
    import sphere_pkg::*;
#(
    parameter int MaxSpheres = 16,
    parameter int IdxW       = $clog2(MaxSpheres)
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      SphWrEn,
    input  logic [IdxW-1:0]           SphWrAddr,
    input  logic signed [COORD_W-1:0] SphWrX,
    input  logic signed [COORD_W-1:0] SphWrY,
    input  logic signed [COORD_W-1:0] SphWrZ,
    input  logic signed [COORD_W-1:0] SphWrR,
    input  logic                      RayValid,
    output logic                      RayReady,
    input  logic signed [COORD_W-1:0] RayX,
    input  logic signed [COORD_W-1:0] RayY,
    input  logic signed [COORD_W-1:0] RayZ,
    input  logic signed [COORD_W-1:0] RayDX,
    input  logic signed [COORD_W-1:0] RayDY,
    input  logic signed [COORD_W-1:0] RayDZ,
    input  logic [IdxW:0]             NumSpheres,
    output logic signed [COORD_W-1:0] CalcSphereX,
    output logic signed [COORD_W-1:0] CalcSphereY,
    output logic signed [COORD_W-1:0] CalcSphereZ,
    output logic signed [COORD_W-1:0] CalcSphereR,
    output logic signed [COORD_W-1:0] CalcRayX,
    output logic signed [COORD_W-1:0] CalcRayY,
    output logic signed [COORD_W-1:0] CalcRayZ,
    output logic signed [COORD_W-1:0] CalcRayDX,
    output logic signed [COORD_W-1:0] CalcRayDY,
    output logic signed [COORD_W-1:0] CalcRayDZ,
    output logic                      CalcInputValid,
    input  logic                      CalcInputReady,
    input  logic                      CalcOutputReady,
    input  logic                      CalcIntersects,
    input  logic signed [COORD_W-1:0] CalcDisc,
    input  logic signed [COORD_W-1:0] CalcB,
    output logic                      HitValid,
    input  logic                      HitReady,
    output logic                      Hit,
    output logic [IdxW-1:0]           HitIndex,
    output logic signed [COORD_W-1:0] HitB,
    output logic signed [COORD_W-1:0] HitDisc
);

    localparam logic [IdxW:0] MaxCnt = (IdxW+1)'(MaxSpheres);
    localparam logic [IdxW:0] One    = (IdxW+1)'(1);

    sched_state_e              state_q;
    logic                      ray_ready_q;
    logic                      calc_valid_q;
    logic                      hit_valid_q;
    ray_t                      ray_q;
    logic [IdxW:0]             cnt_q;
    logic [IdxW:0]             issue_idx_q;
    logic [IdxW:0]             res_idx_q;
    logic                      found_q;
    logic [IdxW-1:0]           best_idx_q;
    logic signed [COORD_W-1:0] best_b_q;
    logic signed [COORD_W-1:0] best_disc_q;

    logic [IdxW:0]   cnt_d;
    logic [IdxW:0]   cnt_m1;
    logic [IdxW:0]   issue_idx_d;
    logic            ray_accept;
    logic            issue_fire;
    logic            last_issue;
    logic            collecting;
    logic            candidate;
    logic            tbl_wr_en;
    logic            tbl_rd_en;
    logic [IdxW-1:0] tbl_rd_addr;
    sphere_t         tbl_wr_data;
    sphere_t         tbl_rd_data;

    always_comb begin
        cnt_d       = (NumSpheres > MaxCnt) ? MaxCnt : NumSpheres;
        cnt_m1      = cnt_q - One;
        issue_idx_d = issue_idx_q + One;
        ray_accept  = (state_q == ST_IDLE) && ray_ready_q && RayValid;
        issue_fire  = (state_q == ST_ISSUE) && calc_valid_q && CalcInputReady;
        last_issue  = (issue_idx_q == cnt_m1);
        collecting  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        candidate   = CalcIntersects && (CalcB < 16'sd0);
        tbl_wr_en   = SphWrEn && (state_q == ST_IDLE) && !Reset;
        tbl_rd_en   = 1'b0;
        tbl_rd_addr = '0;
        // The read register doubles as the sphere operand register, so it is
        // only reloaded when a new issue index becomes current.
        if (ray_accept && (cnt_d != '0)) begin
            tbl_rd_en   = 1'b1;
            tbl_rd_addr = '0;
        end else if (issue_fire && !last_issue) begin
            tbl_rd_en   = 1'b1;
            tbl_rd_addr = issue_idx_d[IdxW-1:0];
        end
    end

    always_comb begin
        tbl_wr_data   = '0;
        tbl_wr_data.x = SphWrX;
        tbl_wr_data.y = SphWrY;
        tbl_wr_data.z = SphWrZ;
        tbl_wr_data.r = SphWrR;
    end

    sphere_table #(
        .MaxSpheres(MaxSpheres),
        .IdxW      (IdxW)
    ) u_table (
        .clk_i    (CLK),
        .rst_i    (Reset),
        .wr_en_i  (tbl_wr_en),
        .wr_addr_i(SphWrAddr),
        .wr_data_i(tbl_wr_data),
        .rd_en_i  (tbl_rd_en),
        .rd_addr_i(tbl_rd_addr),
        .rd_data_o(tbl_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            ray_ready_q  <= 1'b0;
            calc_valid_q <= 1'b0;
            hit_valid_q  <= 1'b0;
            ray_q        <= '0;
            cnt_q        <= '0;
            issue_idx_q  <= '0;
            res_idx_q    <= '0;
            found_q      <= 1'b0;
            best_idx_q   <= '0;
            best_b_q     <= '0;
            best_disc_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ray_ready_q <= 1'b1;
                    if (ray_accept) begin
                        ray_ready_q <= 1'b0;
                        ray_q.x     <= RayX;
                        ray_q.y     <= RayY;
                        ray_q.z     <= RayZ;
                        ray_q.dx    <= RayDX;
                        ray_q.dy    <= RayDY;
                        ray_q.dz    <= RayDZ;
                        cnt_q       <= cnt_d;
                        issue_idx_q <= '0;
                        res_idx_q   <= '0;
                        found_q     <= 1'b0;
                        best_idx_q  <= '0;
                        best_b_q    <= '0;
                        best_disc_q <= '0;
                        if (cnt_d == '0) begin
                            state_q     <= ST_DONE;
                            hit_valid_q <= 1'b1;
                        end else begin
                            state_q      <= ST_ISSUE;
                            calc_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_fire) begin
                        issue_idx_q <= issue_idx_d;
                        if (last_issue) begin
                            calc_valid_q <= 1'b0;
                            state_q      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (CalcOutputReady && (res_idx_q == cnt_m1)) begin
                        state_q     <= ST_DONE;
                        hit_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (HitReady) begin
                        hit_valid_q <= 1'b0;
                        ray_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Results come back in issue order, so the result counter names the sphere.
            if (collecting && CalcOutputReady) begin
                res_idx_q <= res_idx_q + One;
                if (candidate && (!found_q || (CalcB > best_b_q))) begin
                    found_q     <= 1'b1;
                    best_idx_q  <= res_idx_q[IdxW-1:0];
                    best_b_q    <= CalcB;
                    best_disc_q <= CalcDisc;
                end
            end
        end
    end

    assign RayReady       = ray_ready_q;
    assign CalcInputValid = calc_valid_q;
    assign HitValid       = hit_valid_q;
    assign Hit            = found_q;
    assign HitIndex       = best_idx_q;
    assign HitB           = best_b_q;
    assign HitDisc        = best_disc_q;
    assign CalcSphereX    = tbl_rd_data.x;
    assign CalcSphereY    = tbl_rd_data.y;
    assign CalcSphereZ    = tbl_rd_data.z;
    assign CalcSphereR    = tbl_rd_data.r;
    assign CalcRayX       = ray_q.x;
    assign CalcRayY       = ray_q.y;
    assign CalcRayZ       = ray_q.z;
    assign CalcRayDX      = ray_q.dx;
    assign CalcRayDY      = ray_q.dy;
    assign CalcRayDZ      = ray_q.dz;

endmodule

// File: tb/tb_sphere_scan_scheduler.sv
// Directed bench for sphere_scan_scheduler with a behavioural discriminant calculator.
module tb_sphere_scan_scheduler;

    localparam int IdxW = 4;

    logic              clk;
    logic              rst;
    logic              SphWrEn;
    logic [IdxW-1:0]   SphWrAddr;
    logic signed [15:0] SphWrX, SphWrY, SphWrZ, SphWrR;
    logic              RayValid;
    logic              RayReady;
    logic signed [15:0] RayX, RayY, RayZ, RayDX, RayDY, RayDZ;
    logic [IdxW:0]     NumSpheres;
    logic signed [15:0] CalcSphereX, CalcSphereY, CalcSphereZ, CalcSphereR;
    logic signed [15:0] CalcRayX, CalcRayY, CalcRayZ, CalcRayDX, CalcRayDY, CalcRayDZ;
    logic              CalcInputValid;
    logic              calc_rdy;
    logic              c_strobe;
    logic              c_hit;
    logic signed [15:0] c_disc, c_b;
    logic              HitValid;
    logic              HitReady;
    logic              Hit;
    logic [IdxW-1:0]   HitIndex;
    logic signed [15:0] HitB, HitDisc;

    int checks   = 0;
    int failures = 0;

    sphere_scan_scheduler #(.MaxSpheres(16)) dut (
        .CLK(clk), .Reset(rst),
        .SphWrEn(SphWrEn), .SphWrAddr(SphWrAddr),
        .SphWrX(SphWrX), .SphWrY(SphWrY), .SphWrZ(SphWrZ), .SphWrR(SphWrR),
        .RayValid(RayValid), .RayReady(RayReady),
        .RayX(RayX), .RayY(RayY), .RayZ(RayZ),
        .RayDX(RayDX), .RayDY(RayDY), .RayDZ(RayDZ),
        .NumSpheres(NumSpheres),
        .CalcSphereX(CalcSphereX), .CalcSphereY(CalcSphereY),
        .CalcSphereZ(CalcSphereZ), .CalcSphereR(CalcSphereR),
        .CalcRayX(CalcRayX), .CalcRayY(CalcRayY), .CalcRayZ(CalcRayZ),
        .CalcRayDX(CalcRayDX), .CalcRayDY(CalcRayDY), .CalcRayDZ(CalcRayDZ),
        .CalcInputValid(CalcInputValid), .CalcInputReady(calc_rdy),
        .CalcOutputReady(c_strobe), .CalcIntersects(c_hit),
        .CalcDisc(c_disc), .CalcB(c_b),
        .HitValid(HitValid), .HitReady(HitReady),
        .Hit(Hit), .HitIndex(HitIndex), .HitB(HitB), .HitDisc(HitDisc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural calculator: fixed latency, in-order results, cleared by reset.
    typedef struct {
        int                 due;
        logic               hit;
        logic signed [15:0] b;
        logic signed [15:0] d;
    } res_t;

    res_t               rq[$];
    logic signed [15:0] issued_y[$];
    int                 issue_cnt = 0;
    int                 cyc = 0;
    int                 lat = 3;

    always @(posedge clk) begin
        int ox, oy, oz, a, b, c, d;
        cyc++;
        if (rst) begin
            rq.delete();
        end else if (CalcInputValid && calc_rdy) begin
            ox = CalcRayX - CalcSphereX;
            oy = CalcRayY - CalcSphereY;
            oz = CalcRayZ - CalcSphereZ;
            a  = CalcRayDX*CalcRayDX + CalcRayDY*CalcRayDY + CalcRayDZ*CalcRayDZ;
            b  = 2 * (ox*CalcRayDX + oy*CalcRayDY + oz*CalcRayDZ);
            c  = ox*ox + oy*oy + oz*oz - CalcSphereR*CalcSphereR;
            d  = b*b - 4*a*c;
            issue_cnt++;
            issued_y.push_back(CalcSphereY);
            rq.push_back('{cyc + lat, (d >= 0), 16'(b), 16'(d)});
        end
        #1;
        c_strobe = 1'b0;
        if (!rst && rq.size() > 0 && rq[0].due <= cyc) begin
            c_strobe = 1'b1;
            c_hit    = rq[0].hit;
            c_b      = rq[0].b;
            c_disc   = rq[0].d;
            void'(rq.pop_front());
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sphere(input int idx, input int x, input int y, input int z, input int r);
        SphWrEn   = 1'b1;
        SphWrAddr = IdxW'(idx);
        SphWrX    = 16'(x);
        SphWrY    = 16'(y);
        SphWrZ    = 16'(z);
        SphWrR    = 16'(r);
        tick();
        SphWrEn   = 1'b0;
    endtask

    // Ray (0,10,0) heading -Y; held for one edge while RayReady is high.
    task automatic start_ray(input int n);
        NumSpheres = (IdxW+1)'(n);
        RayX = 16'sd0; RayY = 16'sd10; RayZ = 16'sd0;
        RayDX = 16'sd0; RayDY = -16'sd1; RayDZ = 16'sd0;
        RayValid = 1'b1;
        tick();
        RayValid = 1'b0;
    endtask

    task automatic wait_hit(input string tag);
        int n = 0;
        while (HitValid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (HitValid !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_hit(input string tag, input int h, input int idx, input int b, input int d);
        chk({tag, "_hit"},  int'(Hit), h);
        chk({tag, "_idx"},  int'(HitIndex), idx);
        chk({tag, "_b"},    int'(HitB), b);
        chk({tag, "_disc"}, int'(HitDisc), d);
    endtask

    task automatic release_hit(input string tag);
        HitReady = 1'b1;
        tick();
        HitReady = 1'b0;
        chk({tag, "_hv_clr"}, int'(HitValid), 0);
        chk({tag, "_rdy_back"}, int'(RayReady), 1);
    endtask

    initial begin
        int base;
        rst = 1'b1; SphWrEn = 1'b0; SphWrAddr = '0;
        SphWrX = '0; SphWrY = '0; SphWrZ = '0; SphWrR = '0;
        RayValid = 1'b0; NumSpheres = '0; calc_rdy = 1'b1; HitReady = 1'b0;
        RayX = '0; RayY = '0; RayZ = '0; RayDX = '0; RayDY = '0; RayDZ = '0;
        tick();
        tick();
        chk("rst_rayready", int'(RayReady), 0);
        chk("rst_calcvalid", int'(CalcInputValid), 0);
        chk("rst_hitvalid", int'(HitValid), 0);
        check_hit("rst", 0, 0, 0, 0);
        chk("rst_opnd_sx", int'(CalcSphereX), 0);
        rst = 1'b0;
        tick();
        chk("idle_rayready", int'(RayReady), 1);

        // Scene A: sphere 0 is missed, sphere 1 is the only hit.
        write_sphere(0, 10, -10, 10, 2);
        chk("wr_rayready", int'(RayReady), 1);
        chk("wr_calcvalid", int'(CalcInputValid), 0);
        chk("wr_hitvalid", int'(HitValid), 0);
        write_sphere(1, 0, 0, 0, 2);
        base = issue_cnt;
        start_ray(2);
        chk("a_first_valid", int'(CalcInputValid), 1);
        chk("a_first_sx", int'(CalcSphereX), 10);
        chk("a_first_ry", int'(CalcRayY), 10);
        chk("a_busy_rdy", int'(RayReady), 0);
        wait_hit("a");
        check_hit("a", 1, 1, -20, 16);
        chk("a_issues", issue_cnt - base, 2);
        release_hit("a");

        // Scene B: both hit, sphere 1 is nearer (B=-20 beats B=-32); hold result.
        write_sphere(0, 0, -6, 0, 2);
        start_ray(2);
        wait_hit("b");
        check_hit("b", 1, 1, -20, 16);
        for (int k = 0; k < 3; k++) tick();
        chk("b_hold_hv", int'(HitValid), 1);
        chk("b_hold_rdy", int'(RayReady), 0);
        check_hit("b_hold", 1, 1, -20, 16);
        release_hit("b");

        // Scene C: identical spheres tie to index 0; stall the second issue.
        write_sphere(0, 0, 0, 0, 2);
        base = issue_cnt;
        start_ray(2);
        tick();
        calc_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("c_stall_valid", int'(CalcInputValid), 1);
            chk("c_stall_sx", int'(CalcSphereX), 0);
            chk("c_stall_sr", int'(CalcSphereR), 2);
        end
        chk("c_stall_issues", issue_cnt - base, 1);
        calc_rdy = 1'b1;
        wait_hit("c");
        check_hit("c", 1, 0, -20, 16);
        chk("c_issues", issue_cnt - base, 2);
        release_hit("c");

        // Empty scene: result at T+1 with no hit.
        start_ray(0);
        chk("e_hv_t1", int'(HitValid), 1);
        check_hit("e", 0, 0, 0, 0);
        release_hit("e");

        // Sphere behind the ray (B=+20) is not a candidate.
        write_sphere(0, 0, 20, 0, 2);
        start_ray(1);
        wait_hit("behind");
        check_hit("behind", 0, 0, 0, 0);
        release_hit("behind");

        // Reset while the only result is still outstanding in the calculator.
        lat = 8;
        start_ray(1);
        tick();
        chk("drn_valid", int'(CalcInputValid), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_rayready", int'(RayReady), 0);
        chk("mrst_hv", int'(HitValid), 0);
        chk("mrst_cv", int'(CalcInputValid), 0);
        chk("mrst_sy", int'(CalcSphereY), 0);
        chk("mrst_ry", int'(CalcRayY), 0);
        check_hit("mrst", 0, 0, 0, 0);
        rst = 1'b0;
        lat = 3;
        tick();
        chk("mrst_idle_rdy", int'(RayReady), 1);
        for (int k = 0; k < 12; k++) tick();
        chk("mrst_no_hv", int'(HitValid), 0);

        // Full table: sphere i at y=-30+3i; nearest forward is i=13 (y=9, B=-2).
        for (int i = 0; i < 16; i++) write_sphere(i, 0, -30 + 3*i, 0, 2);
        base = issue_cnt;
        start_ray(16);
        wait_hit("full");
        check_hit("full", 1, 13, -2, 16);
        chk("full_issues", issue_cnt - base, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("full_order%0d", i), int'(issued_y[base + i]), -30 + 3*i);
        release_hit("full");

        // Count above the table depth is clamped.
        base = issue_cnt;
        start_ray(20);
        wait_hit("clamp");
        check_hit("clamp", 1, 13, -2, 16);
        chk("clamp_issues", issue_cnt - base, 16);
        release_hit("clamp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
